mips_cpu_sequencer: RTL

Multi-cycle state sequencer and instruction register for the MIPS CPU. It produces the 3-bit `state` and the decoded instruction fields (`op`, `function_code`, register and immediate fields) that feed `control_decode` directly downstream. It stretches states on memory `waitrequest`, rejects unsupported opcodes, and halts the core when control returns to address 0. The supported instruction set is addiu, addu, jr, lw and sw.

---
 rtl/mips_cpu_pkg.sv | 38 +++
 rtl/mips_cpu_ir.sv | 35 +++
 rtl/mips_cpu_sequencer.sv | 83 ++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core.
// Used by the sequencer and control_decode.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_JR    = 6'b001000;

    function automatic logic is_legal(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            op == OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_JR);
            op == OP_ADDIU: ok = 1'b1;
            op == OP_LW:    ok = 1'b1;
            op == OP_SW:    ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_cpu_ir.sv
// Instruction register with load enable and the
// combinational field slicing seen by decode.
module mips_cpu_ir #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [INSTR_W-1:0] readdata,
    output logic [5:0]         op,
    output logic [5:0]         function_code,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm16
);

    logic [INSTR_W-1:0] ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (load) begin
            ir <= readdata;
        end
    end

    assign op            = ir[31:26];
    assign rs            = ir[25:21];
    assign rt            = ir[20:16];
    assign rd            = ir[15:11];
    assign imm16         = ir[15:0];
    assign function_code = ir[5:0];

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle state sequencer: fetch/decode/exec/mem/wb
// with bus stalls, illegal-op trap, halt on PC=0 and retire count.
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest,
    input  logic [INSTR_W-1:0] readdata,
    input  logic               mem_access,
    input  logic               pc_next_zero,
    output logic [2:0]         state,
    output logic [5:0]         op,
    output logic [5:0]         function_code,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm16,
    output logic               active,
    output logic               illegal,
    output logic [31:0]        retired
);

    state_t state_q;
    state_t state_d;
    logic   ir_load;
    logic   legal;

    assign ir_load = (state_q == ST_FETCH) && !waitrequest;
    assign legal   = is_legal(op, function_code);
    assign state   = state_q;

    mips_cpu_ir #(
        .INSTR_W(INSTR_W)
    ) u_ir (
        .clk          (clk),
        .reset        (reset),
        .load         (ir_load),
        .readdata     (readdata),
        .op           (op),
        .function_code(function_code),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm16        (imm16)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:  if (!waitrequest) state_d = ST_DECODE;
            ST_DECODE: state_d = legal ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_d = ST_MEM;
            // Stall only when this instruction really touches memory.
            ST_MEM:    if (!(mem_access && waitrequest)) state_d = ST_WB;
            ST_WB:     state_d = pc_next_zero ? ST_HALT : ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            active  <= 1'b1;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WB) begin
                retired <= retired + 32'd1;
                if (pc_next_zero) active <= 1'b0;
            end
            if (state_q == ST_DECODE && !legal) begin
                illegal <= 1'b1;
                active  <= 1'b0;
            end
        end
    end

endmodule
